// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one Mux4Way16 between four stream sources.
// Grant is registered and drives the mux select; one bubble between grants.
module mux4way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [1:0]  sel,
    output logic [15:0] out
);
    always_comb begin
        unique case (sel)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
        endcase
    end
endmodule

module mux4_rr_arbiter #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [3:0]        last,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic [3:0]        in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [1:0]        grant,
    output logic              busy
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state, state_d;
    logic [1:0]  grant_d, ptr, ptr_d, pick;
    logic [3:0]  cnt, cnt_d, own_oh;
    logic        own, beat, others, at_lim;

    mux4way16 u_mux (
        .a   (in_data0),
        .b   (in_data1),
        .c   (in_data2),
        .d   (in_data3),
        .sel (grant),
        .out (out_data)
    );

    // Downward scan so the lowest offset from ptr wins.
    always_comb begin
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) pick = ptr + 2'(i);
        end
    end

    always_comb begin
        own_oh    = 4'b0001 << grant;
        own       = req[grant];
        busy      = (state == GRANT);
        out_valid = busy & own;
        out_last  = out_valid & last[grant];
        in_ready  = (out_valid & out_ready) ? own_oh : 4'b0000;
        beat      = out_valid & out_ready;
        others    = |(req & ~own_oh);
        at_lim    = ({1'b0, cnt} + 5'd1) == 5'(MAX_BURST);
    end

    always_comb begin
        state_d = state;
        grant_d = grant;
        ptr_d   = ptr;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    grant_d = pick;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                if (beat && cnt != 4'hf) cnt_d = cnt + 4'd1;
                if (!own || (beat && (last[grant] || (at_lim && others)))) begin
                    state_d = IDLE;
                    ptr_d   = grant + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            grant <= grant_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and random checks of mux4_rr_arbiter against a behavioural model.
module tb_mux4_rr_arbiter;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, last, in_ready;
    logic [15:0] d [4];
    logic        out_valid, out_last, out_ready, busy;
    logic [15:0] out_data;
    logic [1:0]  grant;

    int n_chk = 0;
    int n_pass = 0;
    int m_busy, m_grant, m_ptr, m_cnt;
    int beats [4];
    logic [3:0] acc;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.DATA_W(16), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .in_data0  (d[0]),
        .in_data1  (d[1]),
        .in_data2  (d[2]),
        .in_data3  (d[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_grant = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs();
        logic       ev;
        logic [3:0] er;
        ev = (m_busy != 0) && req[m_grant];
        er = (ev && out_ready) ? 4'(1 << m_grant) : 4'b0000;
        acc = er;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_last", 32'(out_last), 32'(ev && last[m_grant]));
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_data", 32'(out_data), 32'(d[m_grant]));
        chk("grant", 32'(grant), 32'(m_grant));
        chk("busy", 32'(busy), 32'(m_busy != 0));
        for (int i = 0; i < 4; i++) if (in_ready[i]) beats[i]++;
    endtask

    task automatic model_edge();
        bit beat, oth, rel, found;
        if (!rst_n) begin
            model_reset();
        end else if (m_busy == 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req[(m_ptr + k) % 4]) begin
                    m_grant = (m_ptr + k) % 4;
                    found = 1;
                end
            end
            if (found) begin
                m_busy = 1;
                m_cnt  = 0;
            end
        end else begin
            beat = req[m_grant] && out_ready;
            oth  = (req & ~4'(1 << m_grant)) != 4'b0000;
            rel  = !req[m_grant] || (beat && last[m_grant]) ||
                   (beat && (m_cnt + 1 == MB) && oth);
            if (beat && m_cnt < 15) m_cnt++;
            if (rel) begin
                m_ptr  = (m_grant + 1) % 4;
                m_busy = 0;
            end
        end
    endtask

    task automatic cycle();
        #1;
        if (!rst_n) model_reset();
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'b0;
        last = 4'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 16'h1000 * 16'(i + 1);
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Single requester, then ptr should sit at 2.
        req = 4'b0010;
        last = 4'b0010;
        d[1] = 16'hA5A5;
        cycle();
        #1;
        chk("single_data", 32'(out_data), 32'hA5A5);
        chk("single_rdy", 32'(in_ready), 32'b0010);
        cycle();
        req = 4'b0000;
        cycle();
        req = 4'b1111;
        last = 4'b1111;
        cycle();
        #1;
        chk("ptr_after_single", 32'(grant), 32'd2);
        repeat (8) cycle();

        // Round robin from reset: 0,1,2,3,0 with bubbles.
        reset_pulse();
        for (int k = 0; k < 5; k++) begin
            cycle();
            #1;
            chk("rr_grant", 32'(grant), 32'(k % 4));
            chk("rr_valid", 32'(out_valid), 32'd1);
            cycle();
        end

        // Burst limit with a competitor, then solo streaming.
        reset_pulse();
        req = 4'b0011;
        last = 4'b0000;
        for (int i = 0; i < 4; i++) beats[i] = 0;
        repeat (6) cycle();
        chk("burst_beats0", 32'(beats[0]), 32'd4);
        #1;
        chk("burst_next", 32'(grant), 32'd1);
        req = 4'b0001;
        cycle();
        cycle();
        beats[0] = 0;
        repeat (12) cycle();
        chk("solo_beats0", 32'(beats[0]), 32'd12);
        #1;
        chk("solo_busy", 32'(busy), 32'd1);

        // Backpressure.
        reset_pulse();
        req = 4'b0001;
        d[0] = 16'h1234;
        cycle();
        beats[0] = 0;
        cycle();
        out_ready = 1'b0;
        repeat (5) cycle();
        chk("stall_beats", 32'(beats[0]), 32'd1);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("resume_beats", 32'(beats[0]), 32'd4);

        // Withdrawal by owner 2 while 3 waits.
        reset_pulse();
        req = 4'b0100;
        cycle();
        cycle();
        req = 4'b1100;
        cycle();
        req = 4'b1000;
        cycle();
        cycle();
        #1;
        chk("withdraw_next", 32'(grant), 32'd3);
        chk("withdraw_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset between edges mid-grant.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        req = 4'b1111;
        last = 4'b1111;
        cycle();
        #1;
        chk("arst_restart", 32'(grant), 32'd0);

        // Random traffic obeying hold-until-accepted, with rare withdrawal.
        acc = 4'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !acc[i] && $urandom_range(0, 19) != 0) begin
                    req[i] = 1'b1;
                end else begin
                    req[i]  = ($urandom_range(0, 2) != 0);
                    last[i] = ($urandom_range(0, 3) == 0);
                    d[i]    = 16'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
